// File: rtl/ddc_core.sv
// rtl/ddc_core.sv - digital down-converter: NCO phase accumulator, sine ROM and complex mixer.
// Fixed free-running pipeline; valid_out tracks NCO configuration, not data.
module ddc_core #(
    parameter int LATENCY    = 6,
    parameter int LUT_ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    input  logic [47:0] phase_in,
    output logic        valid_out,
    output logic [63:0] ddc_out
);
    localparam int  LUT_SIZE = 1 << LUT_ADDR_W;
    localparam int  SUM_DEPTH = LATENCY - 3;
    localparam real PI = 3.14159265358979323846;

    function automatic logic signed [15:0] sin_entry(int k);
        real x;
        x = 32767.0 * $sin(2.0 * PI * real'(k) / real'(LUT_SIZE));
        return 16'($rtoi($floor(x + 0.5)));
    endfunction

    // One full-wave sine table; cosine is read a quarter turn ahead.
    logic signed [15:0] sin_rom [LUT_SIZE];
    for (genvar g = 0; g < LUT_SIZE; g++) begin : g_rom
        localparam logic signed [15:0] ENTRY = sin_entry(g);
        assign sin_rom[g] = ENTRY;
    end

    logic [19:0] pinc_r, poff_r, acc;
    logic        cfg;
    logic [19:0] ph;
    logic [LUT_ADDR_W-1:0] lut_addr;

    assign ph       = acc + poff_r;
    assign lut_addr = LUT_ADDR_W'(ph >> (20 - LUT_ADDR_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pinc_r <= '0;
            poff_r <= '0;
            acc    <= '0;
            cfg    <= 1'b0;
        end else if (valid_in) begin
            pinc_r <= phase_in[19:0];
            poff_r <= phase_in[43:24];
            acc    <= '0;
            cfg    <= 1'b1;
        end else begin
            acc <= acc + pinc_r;
        end
    end

    logic [31:0]           d1, d2;
    logic [LUT_ADDR_W-1:0] addr1, cos_addr;
    logic signed [15:0]    cos2, sin2;
    logic signed [15:0]    re2, im2;
    logic signed [31:0]    p_rc, p_is, p_ic, p_rs;
    logic [63:0]           sum_pipe [SUM_DEPTH];
    logic [LATENCY-1:0]    vpipe;

    assign cos_addr = addr1 + LUT_ADDR_W'(LUT_SIZE / 4);
    assign re2      = $signed(d2[15:0]);
    assign im2      = $signed(d2[31:16]);

    // Stage 1 pairs each sample with the phase of the same cycle; later stages only add delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1    <= '0;
            addr1 <= '0;
            d2    <= '0;
            cos2  <= '0;
            sin2  <= '0;
            p_rc  <= '0;
            p_is  <= '0;
            p_ic  <= '0;
            p_rs  <= '0;
            vpipe <= '0;
            for (int i = 0; i < SUM_DEPTH; i++) sum_pipe[i] <= '0;
        end else begin
            d1    <= data_in;
            addr1 <= lut_addr;
            d2    <= d1;
            cos2  <= sin_rom[cos_addr];
            sin2  <= sin_rom[addr1];
            p_rc  <= 32'(re2) * 32'(cos2);
            p_is  <= 32'(im2) * 32'(sin2);
            p_ic  <= 32'(im2) * 32'(cos2);
            p_rs  <= 32'(re2) * 32'(sin2);
            sum_pipe[0] <= {p_ic - p_rs, p_rc + p_is};
            for (int i = 1; i < SUM_DEPTH; i++) sum_pipe[i] <= sum_pipe[i-1];
            vpipe <= {vpipe[LATENCY-2:0], cfg};
        end
    end

    assign ddc_out   = sum_pipe[SUM_DEPTH-1];
    assign valid_out = vpipe[LATENCY-1];

    logic unused_phase_bits;
    assign unused_phase_bits = ^{phase_in[47:44], phase_in[23:20]};
endmodule

// File: tb/tb_ddc_core.sv
// tb/tb_ddc_core.sv - scoreboard bench for ddc_core with directed NCO/mixer vectors.
module tb_ddc_core;
    localparam int  LAT = 6;
    localparam real PI  = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic [47:0] phase_in = '0;
    logic        valid_out;
    logic [63:0] ddc_out;

    ddc_core #(.LATENCY(LAT), .LUT_ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .phase_in(phase_in), .valid_out(valid_out), .ddc_out(ddc_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] val; int tol; } exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_on = 1'b1;

    bit          m_cfg = 1'b0;
    logic [19:0] m_pinc = '0, m_poff = '0;
    int          m_n = 0;

    function automatic int rnd(real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic logic [63:0] mk(int re, int im);
        return {32'(im), 32'(re)};
    endfunction

    function automatic logic [63:0] golden(logic [31:0] d, logic [19:0] ph);
        real    a;
        longint c, s, re, im, ro, io;
        a  = 2.0 * PI * real'(int'(ph[19:8])) / 4096.0;
        c  = longint'(rnd(32767.0 * $cos(a)));
        s  = longint'(rnd(32767.0 * $sin(a)));
        re = longint'($signed(d[15:0]));
        im = longint'($signed(d[31:16]));
        ro = re * c + im * s;
        io = im * c - re * s;
        return {io[31:0], ro[31:0]};
    endfunction

    function automatic logic [19:0] m_ph();
        return 20'(32'(m_poff) + 32'(m_n) * 32'(m_pinc));
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // Drive one sample; push its expected output when the model says it will be valid.
    task automatic step(logic [31:0] d, bit vin, logic [19:0] poff, logic [19:0] pinc,
                        bit hand, logic [63:0] hexp, int tol);
        @(posedge clk); #1;
        data_in  = d;
        valid_in = vin;
        phase_in = vin ? {4'hF, poff, 4'hF, pinc} : 48'hFFFF_FFFF_FFFF;
        if (m_cfg) sb.push_back('{val: (hand ? hexp : golden(d, m_ph())), tol: tol});
        if (vin) begin
            m_cfg = 1'b1; m_pinc = pinc; m_poff = poff; m_n = 0;
        end else if (m_cfg) begin
            m_n++;
        end
    endtask

    task automatic run(logic [31:0] d, bit hand, logic [63:0] hexp, int tol);
        step(d, 1'b0, 20'h0, 20'h0, hand, hexp, tol);
    endtask

    always @(negedge clk) begin : monitor
        exp_t   e;
        longint dre, dim;
        if (mon_on && rst_n && valid_out === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL spurious_valid: ddc_out=%h with no expected sample", ddc_out);
            end else begin
                e   = sb.pop_front();
                dre = longint'($signed(ddc_out[31:0])) - longint'($signed(e.val[31:0]));
                dim = longint'($signed(ddc_out[63:32])) - longint'($signed(e.val[63:32]));
                if (dre < 0) dre = -dre;
                if (dim < 0) dim = -dim;
                if (dre <= longint'(e.tol) && dim <= longint'(e.tol)) n_pass++;
                else $display("FAIL mix: got re=%0d im=%0d expected re=%0d im=%0d tol=%0d",
                              $signed(ddc_out[31:0]), $signed(ddc_out[63:32]),
                              $signed(e.val[31:0]), $signed(e.val[63:32]), e.tol);
            end
        end
    end

    localparam logic [31:0] RE1000 = {16'd0, 16'd1000};

    initial begin
        logic [31:0] d;
        real         a;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", ddc_out, 64'd0);
        check("reset_valid", {63'd0, valid_out}, 64'd0);
        rst_n = 1'b1;

        // Unconfigured NCO: cos=32767, sin=0, valid_out low.
        repeat (LAT + 2) run(RE1000, 1'b1, 64'd0, 0);
        check("preconfig_out", ddc_out, mk(32767000, 0));
        check("preconfig_valid", {63'd0, valid_out}, 64'd0);

        step(RE1000, 1'b1, 20'h0, 20'h0, 1'b1, 64'd0, 0);
        repeat (10) run(RE1000, 1'b1, mk(32767000, 0), 0);

        // 90 degree offset; the strobe-cycle sample still sees the old phase.
        step(RE1000, 1'b1, 20'h40000, 20'h0, 1'b1, mk(32767000, 0), 0);
        repeat (10) run(RE1000, 1'b1, mk(0, -32767000), 0);

        // Retime to 180 degrees mid-stream; valid_out must not drop.
        step(RE1000, 1'b1, 20'h80000, 20'h0, 1'b1, mk(0, -32767000), 0);
        for (int k = 0; k < 8; k++) begin
            run(RE1000, 1'b1, mk(-32767000, 0), 0);
            check("retime_valid", {63'd0, valid_out}, 64'd1);
        end

        // Matched-frequency tone: output settles near 16000*32767.
        step(RE1000, 1'b1, 20'h0, 20'h01000, 1'b0, 64'd0, 0);
        for (int n = 0; n < 300; n++) begin
            a = 2.0 * PI * real'(n) / 256.0;
            d = {16'(rnd(16000.0 * $sin(a))), 16'(rnd(16000.0 * $cos(a)))};
            run(d, 1'b1, mk(524272000, 0), 60000);
        end

        // Negative step wraps the accumulator every cycle; exact golden check with extreme inputs.
        step(RE1000, 1'b1, 20'h12345, 20'hFF000, 1'b0, 64'd0, 0);
        for (int n = 0; n < 300; n++) begin
            d = {16'(32767 - n * 811), 16'(n * 1237 - 32768)};
            run(d, 1'b0, 64'd0, 0);
        end

        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", ddc_out, 64'd0);
        check("async_reset_valid", {63'd0, valid_out}, 64'd0);
        sb.delete();
        m_cfg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_reset_out", ddc_out, 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            run(RE1000, 1'b1, 64'd0, 0);
            if (k % 4 == 3) check("post_reset_valid", {63'd0, valid_out}, 64'd0);
        end
        step(RE1000, 1'b1, 20'h0, 20'h0, 1'b1, 64'd0, 0);
        for (int k = 1; k <= LAT + 4; k++) begin
            run(RE1000, 1'b1, mk(32767000, 0), 0);
            if (k == LAT) check("valid_rise_early", {63'd0, valid_out}, 64'd0);
            if (k == LAT + 1) check("valid_rise", {63'd0, valid_out}, 64'd1);
        end

        repeat (LAT) @(posedge clk);
        @(negedge clk); #1;
        mon_on = 1'b0;
        check("drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
